// File: rtl/dmem_arbiter.sv
// Two-requester (core / DMA) arbiter in front of a single-port data memory.
// Optional DMEM_ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed core priority.
module dmem_arbiter #(
  parameter int unsigned addr_data_width = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       core_req,
  input  logic                       core_we,
  input  logic [addr_data_width-1:0] core_addr,
  input  logic [addr_data_width-1:0] core_wdata,
  output logic                       core_gnt,
  output logic                       core_rvalid,
  output logic [addr_data_width-1:0] core_rdata,
  input  logic                       dma_req,
  input  logic                       dma_we,
  input  logic [addr_data_width-1:0] dma_addr,
  input  logic [addr_data_width-1:0] dma_wdata,
  output logic                       dma_gnt,
  output logic                       dma_rvalid,
  output logic [addr_data_width-1:0] dma_rdata,
  output logic                       mem_wr_en,
  output logic                       mem_r_en,
  output logic [addr_data_width-1:0] mem_addr,
  output logic [addr_data_width-1:0] mem_data_in,
  input  logic [addr_data_width-1:0] mem_data_out,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {OWN_CORE = 1'b0, OWN_DMA = 1'b1} owner_t;

  state_t                     state_q, state_d;
  owner_t                     owner_q, owner_d;
  logic [addr_data_width-1:0] core_rdata_q, core_rdata_d;
  logic [addr_data_width-1:0] dma_rdata_q, dma_rdata_d;
  logic                       dma_wins;
  logic                       owner_we;
  logic [addr_data_width-1:0] owner_addr;
  logic [addr_data_width-1:0] owner_wdata;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  owner_t                     last_q, last_d;
`endif

  // Winner selection when leaving IDLE; a lone requester always wins.
`ifdef DMEM_ARB_ROUND_ROBIN_EN
  assign dma_wins = dma_req && (!core_req || (last_q == OWN_CORE));
`else
  assign dma_wins = dma_req && !core_req;
`endif

  // Owner's live qualifiers feed the memory during ACCESS.
  assign owner_we    = (owner_q == OWN_DMA) ? dma_we    : core_we;
  assign owner_addr  = (owner_q == OWN_DMA) ? dma_addr  : core_addr;
  assign owner_wdata = (owner_q == OWN_DMA) ? dma_wdata : core_wdata;

  assign core_rdata = core_rdata_q;
  assign dma_rdata  = dma_rdata_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_CORE;
      core_rdata_q <= '0;
      dma_rdata_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q       <= OWN_DMA;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      core_rdata_q <= core_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    core_rdata_d = core_rdata_q;
    dma_rdata_d  = dma_rdata_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif
    core_gnt     = 1'b0;
    dma_gnt      = 1'b0;
    core_rvalid  = 1'b0;
    dma_rvalid   = 1'b0;
    mem_wr_en    = 1'b0;
    mem_r_en     = 1'b0;
    mem_addr     = '0;
    mem_data_in  = '0;
    busy         = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (core_req || dma_req) begin
          owner_d = dma_wins ? OWN_DMA : OWN_CORE;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Completes even if the owner dropped req early, using whatever it drives now.
        core_gnt    = (owner_q == OWN_CORE);
        dma_gnt     = (owner_q == OWN_DMA);
        mem_addr    = owner_addr;
        mem_data_in = owner_wdata;
        mem_wr_en   = owner_we;
        mem_r_en    = !owner_we;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        last_d      = owner_q;
`endif
        if (owner_we) begin
          state_d = IDLE;
        end else begin
          if (owner_q == OWN_DMA) dma_rdata_d  = mem_data_out;
          else                    core_rdata_d = mem_data_out;
          state_d = RESP;
        end
      end
      RESP: begin
        core_rvalid = (owner_q == OWN_CORE);
        dma_rvalid  = (owner_q == OWN_DMA);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a transaction-level model predicts grant order and
// read data; a negedge monitor checks every gnt/rvalid and the idle bus against it.
module tb_dmem_arbiter;

  localparam int unsigned W = 32;

  logic         clk, reset_n;
  logic         core_req, core_we, core_gnt, core_rvalid;
  logic [W-1:0] core_addr, core_wdata, core_rdata;
  logic         dma_req, dma_we, dma_gnt, dma_rvalid;
  logic [W-1:0] dma_addr, dma_wdata, dma_rdata;
  logic         mem_wr_en, mem_r_en, busy;
  logic [W-1:0] mem_addr, mem_data_in, mem_data_out;

  dmem_arbiter #(.addr_data_width(W)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_wr_en(mem_wr_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory seen by the DUT, and the model's own copy of its contents.
  logic [W-1:0] dut_mem [16];
  logic [W-1:0] ref_mem [16];
  assign mem_data_out = dut_mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_wr_en) dut_mem[mem_addr[5:2]] <= mem_data_in;

  typedef struct packed {
    logic         who;     // 0 = core, 1 = dma
    logic         is_rv;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
    int           cyc;     // -1 = timing not checked
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic void chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: actual=event required=none (cycle %0d)", nm, cyc);
  endfunction

  // Monitor
  logic [W-1:0] hold_c = '0, hold_d = '0;
  exp_t         me;
  int           nact;
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_ctrl", W'({core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_wr_en, mem_r_en, busy}), '0);
      chk("reset_bus", mem_addr | mem_data_in | core_rdata | dma_rdata, '0);
      hold_c = '0;
      hold_d = '0;
    end else begin
      nact = int'(core_gnt) + int'(dma_gnt) + int'(core_rvalid) + int'(dma_rvalid);
      chk("onehot", W'(nact <= 1), W'(1));
      chk("busy", W'(busy), W'(nact != 0));
      if (core_gnt || dma_gnt) begin
        if (sbq.size() == 0) fail_now("unexpected_gnt");
        else begin
          me = sbq.pop_front();
          chk("gnt_kind", W'(me.is_rv), W'(0));
          chk("gnt_owner", W'(dma_gnt), W'(me.who));
          chk("gnt_addr", mem_addr, me.addr);
          chk("gnt_wdata", mem_data_in, me.wdata);
          chk("gnt_wr_en", W'(mem_wr_en), W'(me.we));
          chk("gnt_r_en", W'(mem_r_en), W'(!me.we));
          if (me.cyc >= 0) chk("gnt_cycle", W'(cyc), W'(me.cyc));
        end
      end else begin
        chk("idle_bus", mem_addr | mem_data_in, '0);
        chk("idle_strobes", W'({mem_wr_en, mem_r_en}), '0);
      end
      if (core_rvalid || dma_rvalid) begin
        if (sbq.size() == 0) fail_now("unexpected_rvalid");
        else begin
          me = sbq.pop_front();
          chk("rv_kind", W'(me.is_rv), W'(1));
          chk("rv_owner", W'(dma_rvalid), W'(me.who));
          chk("rv_data", dma_rvalid ? dma_rdata : core_rdata, me.rdata);
          if (me.cyc >= 0) chk("rv_cycle", W'(cyc), W'(me.cyc));
          if (me.who) hold_d = me.rdata;
          else        hold_c = me.rdata;
        end
      end
      chk("core_rdata_hold", core_rdata, hold_c);
      chk("dma_rdata_hold", dma_rdata, hold_d);
    end
  end

  // Transaction-level model: pending flags per requester and who was served last.
  bit c_pend = 0, d_pend = 0;
  bit m_last = 1'b1;

  task automatic issue(input bit who, input bit we, input logic [W-1:0] addr, input logic [W-1:0] wd);
    if (who) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; d_pend = 1;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = addr; core_wdata = wd; c_pend = 1;
    end
  endtask

  task automatic serve_one(input int gcyc);
    bit   w, got;
    exp_t e;
    if (!c_pend && !d_pend) return;
    if (c_pend && d_pend) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      w = ~m_last;
`else
      w = 1'b0;
`endif
    end else w = d_pend;
    e.who   = w;
    e.is_rv = 1'b0;
    e.we    = w ? dma_we : core_we;
    e.addr  = w ? dma_addr : core_addr;
    e.wdata = w ? dma_wdata : core_wdata;
    e.rdata = ref_mem[e.addr[5:2]];
    e.cyc   = gcyc;
    sbq.push_back(e);
    if (e.we) ref_mem[e.addr[5:2]] = e.wdata;
    else begin
      e.is_rv = 1'b1;
      e.cyc   = (gcyc < 0) ? -1 : gcyc + 1;
      sbq.push_back(e);
    end
    m_last = w;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (w ? dma_gnt : core_gnt) begin got = 1; break; end
    end
    if (!got) begin
      fail_now("gnt_wait_timeout");
      sbq.delete();
      core_req = 1'b0; dma_req = 1'b0; c_pend = 0; d_pend = 0;
      return;
    end
    @(posedge clk); #1;
    if (w) begin dma_req = 1'b0; d_pend = 0; end
    else   begin core_req = 1'b0; c_pend = 0; end
  endtask

  task automatic settle();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (!busy) break;
    end
  endtask

  function automatic logic [W-1:0] raddr();
    return {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    int k;
    logic [W-1:0] v;
    reset_n = 1'b0;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      dut_mem[i] = v;
      ref_mem[i] = v;
    end
    dut_mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_busy", W'(busy), W'(0));
    chk("post_reset_rdata", core_rdata | dma_rdata, '0);

    // Core read 0x10 returning 0xDEADBEEF: gnt at +1, rvalid at +2.
    settle(); k = cyc;
    issue(0, 0, 32'h10, $urandom);
    serve_one(k + 1);
    // DMA write 0x04: gnt + write at +1, idle at +2.
    settle(); k = cyc;
    issue(1, 1, 32'h04, 32'h12345678);
    serve_one(k + 1);
    chk("idle_after_write", W'(busy), W'(0));
    // Core write then read of 0x08 back-to-back.
    v = $urandom;
    settle(); k = cyc;
    issue(0, 1, 32'h08, v);
    serve_one(k + 1);
    k = cyc;
    issue(0, 0, 32'h08, $urandom);
    serve_one(k + 1);

    // Both requesters reading continuously.
    settle();
    for (int r = 0; r < 4; r++) begin
      if (!c_pend) issue(0, 0, raddr(), $urandom);
      if (!d_pend) issue(1, 0, raddr(), $urandom);
      serve_one(-1);
    end
    while (c_pend || d_pend) serve_one(-1);

    // Randomized mixed traffic.
    for (int r = 0; r < 200; r++) begin
      if (!c_pend && $urandom_range(0, 2) != 0) issue(0, 1'($urandom_range(0, 1)), raddr(), $urandom);
      if (!d_pend && $urandom_range(0, 2) != 0) issue(1, 1'($urandom_range(0, 1)), raddr(), $urandom);
      if (c_pend || d_pend) serve_one(-1);
      else begin @(posedge clk); #1; end
    end
    while (c_pend || d_pend) serve_one(-1);
    settle(); settle();

    // Reset pulsed during RESP of a core read: the rvalid must never appear.
    k = cyc;
    issue(0, 0, 32'h10, $urandom);
    serve_one(k + 1);
    reset_n = 1'b0;
    if (sbq.size() > 0) void'(sbq.pop_back());
    m_last = 1'b1;
    #1;
    chk("abort_ctrl", W'({core_gnt, core_rvalid, dma_gnt, dma_rvalid, mem_wr_en, mem_r_en, busy}), '0);
    chk("abort_rdata", core_rdata, '0);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rdata_after_reset", core_rdata, '0);
    chk("busy_after_reset", W'(busy), W'(0));

    // Recovery: a fresh DMA read after reset.
    k = cyc;
    issue(1, 0, 32'h10, $urandom);
    serve_one(k + 1);
    settle(); settle();
    chk("scoreboard_empty", W'(sbq.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
